// File: rtl/aes_pkg.sv
// aes_pkg: shared opcode encoding for the AES round scheduler.
package aes_pkg;
    typedef enum logic [2:0] {
        NOOP            = 3'd0,
        AESENC          = 3'd1,
        AESENCLAST      = 3'd2,
        AESENCFULL      = 3'd3,
        AESKEYGENASSIST = 3'd4
    } opcode;
endpackage

// File: rtl/aes_round_sched.sv
// aes_round_sched: AES round/key-schedule control FSM.
// Define AES_SBOX_WAIT_EN to insert one SBOX wait cycle before every ROUND cycle.
module aes_round_sched
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  opcode      opcode_i,
    input  logic [7:0] rcon_i,
    output logic       ready_o,
    output logic       zero_rnd_o,
    output logic       full_enc_o,
    output logic       final_rnd_o,
    output logic       key_sub_o,
    output logic       gen_key_o,
    output logic       next_rnd_o,
    output logic [7:0] rcon_o,
    output logic [3:0] round_o,
    output logic       done_o
);
`ifdef AES_SBOX_WAIT_EN
    typedef enum logic [2:0] {IDLE, INIT, ROUND, KEYGEN, DONE, SBOX} state_t;
    localparam state_t RND_ENTRY = SBOX;
`else
    typedef enum logic [2:0] {IDLE, INIT, ROUND, KEYGEN, DONE} state_t;
    localparam state_t RND_ENTRY = ROUND;
`endif
    state_t     r_state, w_nstate;
    opcode      r_op, w_nop;
    logic [3:0] r_round, w_nround;
    logic [7:0] r_rcon, w_nrcon, w_xtime;
    logic       w_acc, w_full, w_last, w_single;
    assign w_acc    = start_i && !rst && r_state == IDLE &&
                      (opcode_i inside {AESENC, AESENCLAST, AESENCFULL, AESKEYGENASSIST});
    assign w_single = opcode_i == AESENC || opcode_i == AESENCLAST;
    assign w_full   = r_op == AESENCFULL;
    assign w_last   = !w_full || r_round >= 4'd10;
    assign w_xtime  = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1B : 8'h00);
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_op    <= NOOP;
            r_round <= 4'd0;
            r_rcon  <= 8'h00;
        end else begin
            r_state <= w_nstate;
            r_op    <= w_nop;
            r_round <= w_nround;
            r_rcon  <= w_nrcon;
        end
    end
    always_comb begin
        w_nstate    = r_state;
        w_nop       = r_op;
        w_nround    = r_round;
        w_nrcon     = r_rcon;
        ready_o     = 1'b0;
        zero_rnd_o  = 1'b0;
        full_enc_o  = 1'b0;
        final_rnd_o = 1'b0;
        key_sub_o   = 1'b0;
        gen_key_o   = 1'b0;
        next_rnd_o  = 1'b0;
        done_o      = 1'b0;
        rcon_o      = 8'h00;
        round_o     = r_round;
        case (r_state)
            IDLE: begin
                ready_o = 1'b1;
                if (w_acc) begin
                    w_nop    = opcode_i;
                    w_nstate = (opcode_i == AESENCFULL) ? INIT :
                               (opcode_i == AESKEYGENASSIST) ? KEYGEN : RND_ENTRY;
                    w_nround = w_single ? 4'd1 : 4'd0;
                    w_nrcon  = (opcode_i == AESENCFULL) ? 8'h01 :
                               (opcode_i == AESKEYGENASSIST) ? rcon_i : 8'h00;
                end
            end
            INIT: begin
                zero_rnd_o = 1'b1;
                w_nstate   = RND_ENTRY;
                w_nround   = 4'd1;
            end
`ifdef AES_SBOX_WAIT_EN
            SBOX: w_nstate = ROUND;
`endif
            ROUND: begin
                full_enc_o  = 1'b1;
                gen_key_o   = w_full;
                next_rnd_o  = w_full;
                rcon_o      = r_rcon;
                final_rnd_o = r_op == AESENCLAST || (w_full && r_round == 4'd10);
                // round and rcon are cleared on exit so idle-side outputs read zero
                w_nstate    = w_last ? DONE : RND_ENTRY;
                w_nround    = w_last ? 4'd0 : r_round + 4'd1;
                w_nrcon     = w_last ? 8'h00 : w_xtime;
            end
            KEYGEN: begin
                key_sub_o = 1'b1;
                gen_key_o = 1'b1;
                rcon_o    = r_rcon;
                w_nstate  = DONE;
                w_nrcon   = 8'h00;
            end
            DONE: begin
                done_o   = 1'b1;
                w_nstate = IDLE;
                w_nop    = NOOP;
            end
            default: w_nstate = IDLE;
        endcase
        if (rst) begin
            ready_o     = 1'b1;
            zero_rnd_o  = 1'b0;
            full_enc_o  = 1'b0;
            final_rnd_o = 1'b0;
            key_sub_o   = 1'b0;
            gen_key_o   = 1'b0;
            next_rnd_o  = 1'b0;
            done_o      = 1'b0;
            rcon_o      = 8'h00;
            round_o     = 4'd0;
        end
    end
endmodule

// File: tb/tb_aes_round_sched.sv
// tb_aes_round_sched: directed scoreboard bench for aes_round_sched.
// Expected per-cycle output vectors are queued when an operation starts and popped every cycle.
module tb_aes_round_sched;
    import aes_pkg::*;
    logic       clk = 1'b0;
    logic       rst, start_i;
    opcode      opcode_i;
    logic [7:0] rcon_i;
    logic       ready_o, zero_rnd_o, full_enc_o, final_rnd_o, key_sub_o, gen_key_o, next_rnd_o, done_o;
    logic [7:0] rcon_o;
    logic [3:0] round_o;
    logic [19:0] w_out;
    logic [19:0] q[$];
    int n_vec = 0, n_err = 0, n_done = 0;
    localparam logic [7:0] RC [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    aes_round_sched dut (
        .clk(clk), .rst(rst), .start_i(start_i), .opcode_i(opcode_i), .rcon_i(rcon_i),
        .ready_o(ready_o), .zero_rnd_o(zero_rnd_o), .full_enc_o(full_enc_o), .final_rnd_o(final_rnd_o),
        .key_sub_o(key_sub_o), .gen_key_o(gen_key_o), .next_rnd_o(next_rnd_o),
        .rcon_o(rcon_o), .round_o(round_o), .done_o(done_o)
    );

    always #5 clk = ~clk;
    assign w_out = {ready_o, zero_rnd_o, full_enc_o, final_rnd_o, key_sub_o, gen_key_o,
                    next_rnd_o, done_o, round_o, rcon_o};

    // flag bits: ready zero full final key_sub gen_key next_rnd done
    function automatic logic [19:0] v(input logic [7:0] f, input logic [3:0] rnd, input logic [7:0] rc);
        return {f, rnd, rc};
    endfunction

    localparam logic [19:0] IDLE_V = {8'h80, 4'd0, 8'h00};
    localparam logic [19:0] DONE_V = {8'h01, 4'd0, 8'h00};

    task automatic chk(input string tag, input logic [19:0] e);
        n_vec++;
        assert (w_out === e) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, w_out, e);
        end
    endtask

    task automatic tick(input string tag);
        logic [19:0] e;
        @(posedge clk);
        @(negedge clk);
        if (done_o) n_done++;
        e = (q.size() > 0) ? q.pop_front() : IDLE_V;
        chk(tag, e);
    endtask

    task automatic push_round(input logic [7:0] f, input logic [3:0] rnd, input logic [7:0] rc);
`ifdef AES_SBOX_WAIT_EN
        q.push_back(v(8'h00, rnd, 8'h00));
`endif
        q.push_back(v(f, rnd, rc));
    endtask

    task automatic push_full();
        q.push_back(v(8'h40, 4'd0, 8'h00));
        for (int k = 1; k <= 10; k++)
            push_round((k == 10) ? 8'h36 : 8'h26, 4'(k), RC[k-1]);
        q.push_back(DONE_V);
    endtask

    // drives one request; with hold, start_i stays high (as AESENC) through the DONE-exit edge
    task automatic op(input opcode o, input logic [7:0] rc, input logic hold, input string tag);
        start_i  = 1'b1;
        opcode_i = o;
        rcon_i   = rc;
        tick(tag);
        rcon_i = 8'h00;
        if (hold) opcode_i = AESENC;
        else start_i = 1'b0;
        while (q.size() > 0) tick(tag);
        tick(tag);
        start_i = 1'b0;
        tick(tag);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start_i = 1'b1; opcode_i = AESENC; rcon_i = 8'h00;
        @(negedge clk);
        chk("reset_pre", IDLE_V);
        tick("reset_hold");
        tick("reset_hold");
        rst = 1'b0; start_i = 1'b0;
        tick("idle_after_reset");

        push_full();
        op(AESENCFULL, 8'h00, 1'b0, "encfull");

        push_round(8'h30, 4'd1, 8'h00);
        q.push_back(DONE_V);
        op(AESENCLAST, 8'h00, 1'b0, "enclast");

        push_round(8'h20, 4'd1, 8'h00);
        q.push_back(DONE_V);
        op(AESENC, 8'h00, 1'b0, "enc");

        q.push_back(v(8'h0C, 4'd0, 8'h1B));
        q.push_back(DONE_V);
        op(AESKEYGENASSIST, 8'h1B, 1'b0, "keygen_1b");

        q.push_back(v(8'h0C, 4'd0, 8'hA5));
        q.push_back(DONE_V);
        op(AESKEYGENASSIST, 8'hA5, 1'b0, "keygen_a5");

        n_done = 0;
        op(NOOP, 8'h00, 1'b0, "noop_start");
        op(opcode'(3'd6), 8'h00, 1'b0, "undef_start");
        n_vec++;
        assert (n_done == 0) else begin
            n_err++;
            $error("FAIL noop_done_count: got %0d want 0", n_done);
        end

        n_done = 0;
        push_full();
        op(AESENCFULL, 8'h00, 1'b1, "full_held_start");
        n_vec++;
        assert (n_done == 1) else begin
            n_err++;
            $error("FAIL held_done_count: got %0d want 1", n_done);
        end

        push_full();
        start_i = 1'b1; opcode_i = AESENCFULL;
        tick("abort_run");
        start_i = 1'b0;
`ifdef AES_SBOX_WAIT_EN
        repeat (10) tick("abort_run");
`else
        repeat (5) tick("abort_run");
`endif
        chk("at_round5", (w_out[11:8] == 4'd5) ? w_out : v(8'h26, 4'd5, 8'h10));
        rst = 1'b1;
        #1;
        chk("rst_mid_outputs", IDLE_V);
        q.delete();
        n_done = 0;
        tick("rst_mid_edge");
        rst = 1'b0;
        repeat (3) tick("after_abort");
        n_vec++;
        assert (n_done == 0) else begin
            n_err++;
            $error("FAIL abort_done_count: got %0d want 0", n_done);
        end

        push_round(8'h20, 4'd1, 8'h00);
        q.push_back(DONE_V);
        op(AESENC, 8'h00, 1'b0, "enc_after_abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/aes_round_sched.md
AES_ROUND_SCHED -- requirements
Module: aes_round_sched

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port start_i  input  1  request strobe; accepted only when ready_o=1.
REQ-004 SHALL have port opcode_i  input  aes_pkg::opcode  operation: NOOP, AESENC, AESENCLAST, AESENCFULL, AESKEYGENASSIST.
REQ-005 SHALL have port rcon_i  input  8  round constant used by AESKEYGENASSIST.
REQ-006 SHALL have port ready_o  output  1  high only in IDLE.
REQ-007 SHALL have ports zero_rnd_o, full_enc_o, final_rnd_o  output  1 each  aes_enc round-type controls.
REQ-008 SHALL have port key_sub_o  output  1  S-box is used for key substitution.
REQ-009 SHALL have ports gen_key_o, next_rnd_o  output  1 each  key_gen controls.
REQ-010 SHALL have port rcon_o  output  8  round constant to key_gen.
REQ-011 SHALL have port round_o  output  4  current round index, 0..10.
REQ-012 SHALL have port done_o  output  1  one-cycle completion pulse.

Function
REQ-013 SHALL implement states IDLE, INIT, SBOX (macro only), ROUND, KEYGEN, DONE as one registered FSM with a 4-bit round counter and an 8-bit rcon register.
REQ-014 SHALL latch opcode_i on acceptance (start_i & ready_o) and hold it until DONE; opcode_i is ignored at all other times.
REQ-015 SHALL treat start_i with NOOP, or with any undefined encoding, as no request: the FSM stays in IDLE and done_o stays 0.
REQ-016 SHALL, on accepting AESENCFULL, go IDLE->INIT, set round=0 and rcon=0x01.
REQ-016a INIT SHALL drive zero_rnd_o=1 and full_enc_o=0.
REQ-017 SHALL run rounds 1..10 in ROUND, with full_enc_o=1 and gen_key_o=1.
REQ-017a final_rnd_o SHALL be 1 only when round_o=10.
REQ-017b next_rnd_o SHALL pulse 1 on the last cycle of each round.
REQ-018 SHALL advance rcon after each round by xtime (shift left 1 bit, XOR 0x1B when bit 7 was set), giving the sequence 01,02,04,08,10,20,40,80,1B,36.
REQ-018a rcon_o SHALL be 0x00 outside ROUND and KEYGEN.
REQ-019 SHALL, on accepting AESENC, go IDLE->ROUND for exactly one round with final_rnd_o=0 and full_enc_o=1, then go to DONE; round_o=1 and gen_key_o=0.
REQ-020 SHALL handle AESENCLAST as for AESENC, but with final_rnd_o=1.
REQ-021 SHALL, on accepting AESKEYGENASSIST, go IDLE->KEYGEN for one cycle with key_sub_o=1, gen_key_o=1 and rcon_o=rcon_i (sampled at acceptance), then go to DONE.
REQ-022 SHALL hold key_sub_o=0 in every state other than KEYGEN.
REQ-023 SHALL spend exactly one cycle in DONE with done_o=1, then return to IDLE; ready_o=0 in DONE, so a start_i in the DONE cycle is ignored.
REQ-024 SHALL, without the macro, give latency from the acceptance edge to done_o=1 of: 12 cycles for AESENCFULL; 2 cycles for AESENC and AESENCLAST; 2 cycles for AESKEYGENASSIST.
REQ-025 SHALL never wrap the round counter past 10.
REQ-025a From ROUND at round 10 the FSM SHALL go only to DONE.
REQ-026 SHALL drive all outputs not named active in a state to 0 in that state.

Reset
REQ-027 SHALL, with rst=1 at a clock edge, force state=IDLE, round=0, rcon=0x00 and latched opcode=NOOP, from any state including mid-operation.
REQ-027a While rst=1, outputs SHALL be 0 except ready_o, which SHALL be 1.
REQ-028 SHALL ignore start_i on any edge where rst=1, and SHALL produce no done_o for an operation aborted by reset.

Configuration
REQ-029 SHALL use macro AES_SBOX_WAIT_EN.
REQ-029a When AES_SBOX_WAIT_EN is defined, every ROUND cycle SHALL be preceded by one SBOX cycle in which all outputs are 0 except round_o.
REQ-029b With AES_SBOX_WAIT_EN defined, next_rnd_o SHALL pulse in the ROUND cycle, and latencies SHALL be 22 cycles for AESENCFULL and 3 cycles for AESENC and AESENCLAST; AESKEYGENASSIST is unchanged.
REQ-030 SHALL, when AES_SBOX_WAIT_EN is undefined, contain no SBOX state, with timing as in REQ-024.

Verification
REQ-031 AESENCFULL (no macro) -> zero_rnd_o in cycle 1, rcon_o 01..36 in cycles 2..11, final_rnd_o only in cycle 11, done_o in cycle 12.
REQ-032 AESENCLAST -> one cycle with full_enc_o=1, final_rnd_o=1, round_o=1; done_o on the next cycle; ready_o=1 after that.
REQ-033 AESKEYGENASSIST with rcon_i=0x1B -> one cycle with key_sub_o=1, gen_key_o=1, rcon_o=0x1B; then done_o.
REQ-034 start_i held high with AESENC during a running AESENCFULL, and NOOP start in IDLE -> no extra operation and exactly one done_o pulse.
REQ-035 rst=1 at round 5 -> next cycle IDLE, all outputs 0 except ready_o=1, no done_o.
REQ-036 AESENCFULL with AES_SBOX_WAIT_EN -> SBOX/ROUND alternate, done_o at cycle 22, next_rnd_o pulses exactly 10 times.
